// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus fabric: region codes and default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mmio_pkg;

  localparam int DEF_DW = 9;
  localparam int DEF_AW = 9;

  // Region code carried in the two top processor address bits.
  typedef enum logic [1:0] {
    REG_MEM  = 2'b00,
    REG_OUT  = 2'b01,
    REG_IN   = 2'b10,
    REG_NONE = 2'b11
  } region_e;

  // A write is legal only to SRAM or to an output register that exists.
  function automatic logic is_bad_write(input region_e region, input logic idx_ok);
    return (region == REG_IN) || (region == REG_NONE) ||
           ((region == REG_OUT) && !idx_ok);
  endfunction

endpackage

// File: rtl/mmio_bus_ctrl_sync_chain.sv
// sync_chain: multi-flop synchroniser for asynchronous inputs, no debounce.
// Latency: STAGES clk cycles from i_d to o_q.
// Backpressure: none; samples every cycle.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset, clears every stage
//   i_d    asynchronous input, W bits
//   o_q    synchronised output, W bits
module sync_chain #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [STAGES-1:0][W-1:0] r_stg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg <= '0;
    end else begin
      r_stg <= {r_stg[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stg[STAGES-1];

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: address decode between processor bus, SRAM, output registers and input port.
// Latency: read data 1 cycle after address in every region; SRAM strobes are combinational.
// Backpressure: none; one access per cycle, illegal writes are dropped and flagged in bus_err.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   proc_addr/dout/wen    processor address, write data, write strobe
//   proc_din              read data, valid one cycle after proc_addr
//   mem_addr/wdata/wren   SRAM address, write data, write enable (combinational)
//   mem_q                 SRAM registered read data
//   out_regs              NUM_OUT output registers, register i at [i*DW +: DW]
//   in_raw, run_raw       asynchronous input pins and Run switch
//   run_sync              synchronised Run (level, or rising-edge pulse with RUN_PULSE_EN)
//   err_clr, bus_err      sticky illegal-write flag and its clear
// Build option: define RUN_PULSE_EN to turn run_sync into a one-cycle rising-edge pulse.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int NUM_OUT     = 2,
  parameter int IN_W        = DW,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         proc_addr,
  input  logic [DW-1:0]         proc_dout,
  input  logic                  proc_wen,
  output logic [DW-1:0]         proc_din,
  output logic [AW-3:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  mem_wren,
  input  logic [DW-1:0]         mem_q,
  output logic [NUM_OUT*DW-1:0] out_regs,
  input  logic [IN_W-1:0]       in_raw,
  input  logic                  run_raw,
  output logic                  run_sync,
  input  logic                  err_clr,
  output logic                  bus_err
);

  // NUM_OUT may equal 2**(AW-2), so the range compare needs one extra bit.
  localparam logic [AW-2:0] LP_NUM_OUT = (AW-1)'(NUM_OUT);

  region_e             w_region;
  logic [AW-3:0]       w_index;
  logic                w_idx_ok;
  logic                w_out_wr;
  logic                w_bad_wr;
  logic [DW-1:0]       w_rd_dat;
  logic [DW-1:0]       w_in_ext;
  logic [IN_W-1:0]     w_in_sync;
  logic                w_run_lvl;

  region_e             r_region;
  logic [AW-3:0]       r_index;
  logic                r_live;
  logic                r_bus_err;
  logic [NUM_OUT*DW-1:0] r_out_regs;

  // ---------------- decode ----------------
  assign w_region = region_e'(proc_addr[AW-1:AW-2]);
  assign w_index  = proc_addr[AW-3:0];
  assign w_idx_ok = ({1'b0, w_index} < LP_NUM_OUT);
  assign w_out_wr = proc_wen && (w_region == REG_OUT) && w_idx_ok;
  assign w_bad_wr = proc_wen && is_bad_write(w_region, w_idx_ok);

  assign mem_addr  = w_index;
  assign mem_wdata = proc_dout;
  assign mem_wren  = proc_wen && (w_region == REG_MEM);

  // ---------------- output registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_regs <= '0;
    end else if (w_out_wr) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_index == (AW-2)'(i)) begin
          r_out_regs[i*DW +: DW] <= proc_dout;
        end
      end
    end
  end

  assign out_regs = r_out_regs;

  // ---------------- read path ----------------
  // Region/index are captured every cycle and the mux runs off the captured copy,
  // lining the other regions up with the SRAM's own one-cycle read latency.
  // r_live keeps proc_din at zero until the first edge after reset, since the
  // captured region resets to the SRAM code and mem_q is not ours to clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_region <= REG_MEM;
      r_index  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_region <= w_region;
      r_index  <= w_index;
      r_live   <= 1'b1;
    end
  end

  always_comb begin
    w_in_ext = '0;
    w_in_ext[IN_W-1:0] = w_in_sync;
  end

  // Output registers are read from their live value, so a read issued in the
  // cycle after (or the same cycle as) a write returns the new contents.
  always_comb begin
    w_rd_dat = '0;
    case (r_region)
      REG_MEM: w_rd_dat = mem_q;
      REG_OUT: begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (r_index == (AW-2)'(i)) begin
            w_rd_dat = r_out_regs[i*DW +: DW];
          end
        end
      end
      REG_IN:  w_rd_dat = w_in_ext;
      default: w_rd_dat = '0;
    endcase
  end

  assign proc_din = r_live ? w_rd_dat : '0;

  // ---------------- sticky error ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_err <= 1'b0;
    end else if (w_bad_wr) begin
      r_bus_err <= 1'b1;   // set beats a simultaneous clear
    end else if (err_clr) begin
      r_bus_err <= 1'b0;
    end
  end

  assign bus_err = r_bus_err;

  // ---------------- synchronisers ----------------
  sync_chain #(.W(1), .STAGES(SYNC_STAGES)) u_run_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (run_raw),
    .o_q   (w_run_lvl)
  );

  sync_chain #(.W(IN_W), .STAGES(SYNC_STAGES)) u_in_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (in_raw),
    .o_q   (w_in_sync)
  );

`ifdef RUN_PULSE_EN
  logic r_run_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_prev <= 1'b0;
    end else begin
      r_run_prev <= w_run_lvl;
    end
  end

  assign run_sync = w_run_lvl & ~r_run_prev;
`else
  assign run_sync = w_run_lvl;
`endif

endmodule
